data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Parametrised byte-addressable data memory for the RISC-V core, replacing the fixed 1024-word, word-only data memory. Supports LB/LH/LW/LBU/LHU and SB/SH/SW via funct3, with byte-lane write enables and sign or zero extension. Uses a valid/ready request port with a registered 1-cycle response. Reports misaligned, out-of-range and illegal-funct3 accesses, and optionally zero-fills the array after reset.

Parameters:
- ADDR_W, 32, width of the byte address.
- DEPTH, 1024, number of 32-bit words; power of two, at least 4.
- INIT_ZERO, 1: 1 = sweep the array to zero after reset; 0 = skip the sweep (array contents undefined).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V access size and sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned in the low bits.
- rsp_valid  out  1  one-cycle pulse, one cycle after an accepted request.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted; qualified by rsp_valid.
- init_done  out  1  high once the block is operational.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - FSM state = INIT if INIT_ZERO=1, else IDLE.
  - The array itself is not reset.
- FSM states: INIT, IDLE.
  - INIT: a word counter runs 0..DEPTH-1 and writes 0 to one word per cycle. req_ready=0. After writing word DEPTH-1, go to IDLE; init_done and req_ready rise on that edge. The sweep takes exactly DEPTH cycles.
  - IDLE: req_ready=1 and init_done=1. The request port is never stalled in IDLE.
  - Reset asserted mid-INIT restarts the sweep from word 0.
- Accept: a request is taken on any clk edge where req_valid && req_ready. Requests are not queued.
- Word index = req_addr[ADDR_W-1:2]; byte offset = req_addr[1:0].
- Error conditions (any one sets err):
  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
  - Out of range: word index ≥ DEPTH.
  - Illegal funct3: loads with 011/110/111; stores with funct3 > 010.
- Store, no error:
  - Byte enables: SB = 1 lane at offset; SH = 2 lanes at offset; SW = all 4 lanes.
  - req_wdata is shifted left by 8×offset.
  - Only enabled lanes update, on the accept edge.
- Store, error: no array write.
- Load, no error:
  - The selected lanes are read from the word, shifted down, then sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
  - The result is registered into rsp_rdata.
- Response: in the cycle after accept, rsp_valid=1, rsp_err=err, and rsp_rdata = load data, or 0 for stores and errors. rsp_valid is 0 in all other cycles. rsp_rdata holds its value until the next response.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- Back-to-back requests: full throughput, one request accepted per cycle.

Decomposition:
- Package dm_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - The state enum {INIT, IDLE}.
  - The 32-bit word-width constant.
- Sub-module dm_lane_align (combinational) takes funct3 and offset. It produces the byte-enable mask, aligned write data, the misalign/illegal flags, and load extract/extend.
- The top level holds the FSM, init counter, array and response registers.

Test Plan:
- Init sweep (INIT_ZERO=1, DEPTH=16): release rst → req_ready and init_done rise exactly 16 cycles later; LW at 0x3C returns 0x00000000, err=0.
- Sub-word stores: SW 0x11223344 @0x8, then SB 0xAA @0x9, then LW @0x8 → 0x1122AA44. Follow with SH 0xBEEF @0xA, then LW @0x8 → 0xBEEFAA44.
- Sign and zero extension (word @0x8 = 0xBEEFAA44):
  - LB @0x9 → 0xFFFFFFAA; LBU @0x9 → 0x000000AA.
  - LH @0xA → 0xFFFFBEEF; LHU @0xA → 0x0000BEEF.
- Faults: each of the following gives err=1, rdata=0, and the memory word is unchanged on readback:
  - LW @0x6 (misaligned).
  - SH @0x3 (misaligned).
  - LW @(DEPTH×4) (out of range).
  - funct3=011 load (illegal).
- Back-to-back: 8 consecutive accepted requests alternating SW/LW to the same word → 8 rsp_valid pulses, each one cycle after its accept; each load returns the preceding store's data.
- Mid-INIT reset: assert rst during cycle 5 of the sweep, release it → req_ready stays 0 for a full DEPTH cycles after release; init_done=0 throughout.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared constants and types for the data memory controller
package dm_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } dm_state_e;

endpackage

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - byte-lane enables, store alignment, access checks and load extension
module dm_lane_align
  import dm_pkg::*;
(
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] rword,
  output logic [3:0]        byte_en,
  output logic [WORD_W-1:0] wdata_aligned,
  output logic              misalign,
  output logic              illegal,
  output logic [WORD_W-1:0] rdata_ext
);

  logic [WORD_W-1:0] rshift;

  always_comb begin
    byte_en       = 4'b0000;
    misalign      = 1'b0;
    illegal       = 1'b0;
    rdata_ext     = '0;
    wdata_aligned = wdata << {offset, 3'b000};
    rshift        = rword >> {offset, 3'b000};

    case (funct3)
      F3_B, F3_BU: byte_en = 4'b0001 << offset;
      F3_H, F3_HU: begin
        byte_en  = 4'b0011 << offset;
        misalign = offset[0];
      end
      F3_W: begin
        byte_en  = 4'b1111;
        misalign = (offset != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    // Stores have no unsigned variants
    if (we && funct3[2]) illegal = 1'b1;

    case (funct3)
      F3_B:    rdata_ext = {{24{rshift[7]}}, rshift[7:0]};
      F3_H:    rdata_ext = {{16{rshift[15]}}, rshift[15:0]};
      F3_BU:   rdata_ext = {24'h000000, rshift[7:0]};
      F3_HU:   rdata_ext = {16'h0000, rshift[15:0]};
      default: rdata_ext = rword;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressable data memory with valid/ready port and init sweep
module data_mem_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int AW = $clog2(DEPTH);

  dm_state_e         state;
  logic [AW-1:0]     init_cnt;
  logic              ready_q;
  logic [WORD_W-1:0] mem [DEPTH];

  logic [AW-1:0]     widx;
  logic              oor;
  logic              init_last;
  logic              accept;
  logic              err;
  logic [3:0]        byte_en;
  logic [WORD_W-1:0] wdata_aligned;
  logic [WORD_W-1:0] rdata_ext;
  logic              misalign;
  logic              illegal;

  assign widx = req_addr[AW+1:2];

  // Any set address bit above the word index lands beyond DEPTH
  generate
    if (ADDR_W > AW + 2) begin : g_oor
      assign oor = |req_addr[ADDR_W-1:AW+2];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  dm_lane_align u_align (
    .we           (req_we),
    .funct3       (req_funct3),
    .offset       (req_addr[1:0]),
    .wdata        (req_wdata),
    .rword        (mem[widx]),
    .byte_en      (byte_en),
    .wdata_aligned(wdata_aligned),
    .misalign     (misalign),
    .illegal      (illegal),
    .rdata_ext    (rdata_ext)
  );

  assign err       = misalign | illegal | oor;
  assign accept    = req_valid & ready_q;
  assign init_last = (state == INIT) && (init_cnt == AW'(DEPTH - 1));
  assign req_ready = ready_q;
  assign init_done = ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT_ZERO ? INIT : IDLE;
      init_cnt <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= (state == IDLE) || init_last;
      if (init_last) begin
        state <= IDLE;
      end else if (state == INIT) begin
        init_cnt <= init_cnt + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_cnt] <= '0;
    end else if (accept && req_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[widx][8*b +: 8] <= wdata_aligned[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err   <= err;
        rsp_rdata <= (!req_we && !err) ? rdata_ext : '0;
      end
    end
  end

endmodule
